register_file_multiport: RTL
============================

// Module: register_file_multiport
//
// PURPOSE
//   Parametrised multi-port register file for CPU cores: NUM_READ_PORTS read ports, NUM_WRITE_PORTS
//   write ports, and internal forwarding with fixed write-port priority. Adds two features:
//   - an optional hardwired zero register;
//   - a per-register busy scoreboard (reserve/clear), so issue logic knows which operands are valid.
//   Sits between decode/issue and the execution units.
//
// PARAMETERS
//   REG_WIDTH        8  data width of each register
//   ADDR_WIDTH       3  address width; NUM_REGS = 2**ADDR_WIDTH
//   NUM_READ_PORTS   2  number of read ports, 1..8
//   NUM_WRITE_PORTS  1  number of write ports, 1..4
//   READ_LATENCY     0  0 = combinational read; 1 = registered read (data and ready)
//   ZERO_REG         0  1 = register 0 always reads 0, ignores writes, never busy
//
// PORTS
//   clock        in   1                          single clock, all state on rising edge
//   reset        in   1                          synchronous, active-high
//   write        in   NUM_WRITE_PORTS            per-port write enable
//   writeAddr    in   NUM_WRITE_PORTS*ADDR_WIDTH packed; port w at [w*ADDR_WIDTH +: ADDR_WIDTH]
//   writeData    in   NUM_WRITE_PORTS*REG_WIDTH  packed, same slicing
//   reserve      in   1                          mark reserveAddr busy (pending producer)
//   reserveAddr  in   ADDR_WIDTH                 register to reserve
//   readAddr     in   NUM_READ_PORTS*ADDR_WIDTH  packed read addresses
//   readData     out  NUM_READ_PORTS*REG_WIDTH   packed read data
//   readReady    out  NUM_READ_PORTS             1 = readData is valid (not awaiting a producer)
//   busyVector   out  NUM_REGS                   current scoreboard, bit i = register i busy
//
// BEHAVIOUR
//   - Reset (synchronous): clears all registers, busy bits, and (READ_LATENCY=1) the readData/readReady
//     registers to 0. write and reserve are ignored in any cycle where reset=1, including mid-stream.
//   - Write: on a clock edge with write[w]=1, reg[writeAddr_w] <= writeData_w.
//     - Two or more ports writing the same address in one cycle: the highest-numbered port wins.
//     - ZERO_REG=1 and address 0: the write is discarded.
//   - Forwarding: a read whose address matches an active write this cycle returns that port's
//     writeData, using the same priority. Otherwise it returns the stored value.
//     ZERO_REG=1 and readAddr=0: read returns 0, with no forwarding.
//   - Scoreboard: busy[a] is set on the edge where reserve=1 and reserveAddr=a. It is cleared on the
//     edge where any write port writes a.
//     - reserve and write to the same address in one cycle: busy ends set (the new producer wins).
//     - ZERO_REG=1: busy[0] is never set.
//   - readReady[r] = !busy[readAddr_r] OR (an active write this cycle hits readAddr_r).
//     A reserve in the same cycle does not affect this cycle's readReady.
//   - READ_LATENCY=0: readData and readReady are combinational from addresses, writes, and state.
//   - READ_LATENCY=1: the forwarded readData/readReady value is captured on the edge and presented
//     the cycle after; latency is exactly 1 cycle, with no stall or handshake.
//   - busyVector is registered state, valid the cycle after a reserve or write.
//   - Out-of-range addresses cannot occur, since all 2**ADDR_WIDTH entries exist.
//
// STRUCTURE
//   - Shared package regfile_pkg holds:
//     - NUM_REGS computation, and pack/unpack slice helpers for the packed port buses;
//     - the write-priority resolve function (address -> winning port, hit flag), which is reused by
//       the issue logic.
//   - One sub-module, regfile_read_port: one read port's forwarding mux, zero-register masking,
//     readReady logic, and the optional output register. It is generated NUM_READ_PORTS times.
//   - Storage and scoreboard live in the top level; the generate loop covers all NUM_REGS entries.
//
// TESTING
//   - Reset: write reg3=0x5A; assert reset 1 cycle with write=1 to reg4 -> all readData=0,
//     busyVector=0, reg4 still 0.
//   - Forwarding: LAT=0, write reg2=0xA5 while readAddr0=2 -> readData0=0xA5 the same cycle.
//     LAT=1 -> readData0=0xA5 on the next cycle.
//   - Port priority: 2 write ports both write reg5, port0=0x11 and port1=0x22
//     -> readback 0x22; a same-cycle forwarded read also returns 0x22.
//   - Scoreboard: reserve reg6 -> next cycle readReady=0 for readAddr=6 and busyVector[6]=1.
//     Write reg6=0x77 -> readReady=1 that cycle, busy cleared after.
//   - Reserve and write to reg1 together -> busyVector[1]=1 afterwards, and reg1 holds the new data.
//   - ZERO_REG=1: write reg0=0xFF and reserve reg0 -> read of 0 returns 0, readReady=1, busyVector[0]=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared helpers for the multi-port register file: sizing, packed-bus unpacking
// and the write-port priority resolver also used by the issue logic.
package regfile_pkg;

  localparam int MAX_WP     = 4;
  localparam int MAX_AW     = 8;
  localparam int WP_IDX_W   = 2;
  localparam int ADDR_BUS_W = MAX_WP * MAX_AW;

  typedef struct packed {
    logic                hit;
    logic [WP_IDX_W-1:0] port;
  } wr_hit_t;

  function automatic int num_regs(input int aw);
    return 1 << aw;
  endfunction

  // Re-lays a densely packed address bus (nports x aw bits) into fixed MAX_AW-wide slots.
  function automatic logic [ADDR_BUS_W-1:0] unpack_addrs(input logic [ADDR_BUS_W-1:0] bus,
                                                          input int aw,
                                                          input int nports);
    logic [ADDR_BUS_W-1:0] res;
    res = '0;
    for (int p = 0; p < MAX_WP; p++) begin
      for (int b = 0; b < MAX_AW; b++) begin
        if (p < nports && b < aw) begin
          res[p*MAX_AW + b] = bus[p*aw + b];
        end
      end
    end
    return res;
  endfunction

  // Highest-numbered enabled port whose address matches wins.
  function automatic wr_hit_t resolve_write(input logic [MAX_WP-1:0]     we,
                                            input logic [ADDR_BUS_W-1:0] waddr,
                                            input logic [MAX_AW-1:0]     addr);
    wr_hit_t res;
    res = '0;
    for (int w = 0; w < MAX_WP; w++) begin
      if (we[w] && (waddr[w*MAX_AW +: MAX_AW] == addr)) begin
        res.hit  = 1'b1;
        res.port = WP_IDX_W'(w);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One read port: write forwarding, zero-register masking, readiness and
// optional one-cycle output register.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int REG_WIDTH       = 8,
  parameter int ADDR_WIDTH      = 3,
  parameter int NUM_WRITE_PORTS = 1,
  parameter int READ_LATENCY    = 0,
  parameter int ZERO_REG        = 0,
  parameter int NUM_REGS        = 8
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [ADDR_WIDTH-1:0]                addr_i,
  input  logic [NUM_REGS*REG_WIDTH-1:0]        regs_i,
  input  logic [NUM_REGS-1:0]                  busy_i,
  input  logic [MAX_WP-1:0]                    wr_en_i,
  input  logic [ADDR_BUS_W-1:0]                waddr_i,
  input  logic [NUM_WRITE_PORTS*REG_WIDTH-1:0] wdata_i,
  output logic [REG_WIDTH-1:0]                 data_o,
  output logic                                 ready_o
);

  wr_hit_t              hit;
  logic [REG_WIDTH-1:0] data_d;
  logic                 ready_d;

  always_comb begin
    hit     = resolve_write(wr_en_i, waddr_i, MAX_AW'(addr_i));
    data_d  = regs_i[addr_i*REG_WIDTH +: REG_WIDTH];
    ready_d = ~busy_i[addr_i];
    if (hit.hit) begin
      data_d  = wdata_i[hit.port*REG_WIDTH +: REG_WIDTH];
      ready_d = 1'b1;
    end
    // The zero register overrides forwarding entirely.
    if ((ZERO_REG != 0) && (addr_i == '0)) begin
      data_d  = '0;
      ready_d = 1'b1;
    end
  end

  generate
    if (READ_LATENCY == 1) begin : g_reg
      logic [REG_WIDTH-1:0] data_q;
      logic                 ready_q;

      always_ff @(posedge clock) begin
        if (reset) begin
          data_q  <= '0;
          ready_q <= 1'b0;
        end else begin
          data_q  <= data_d;
          ready_q <= ready_d;
        end
      end

      assign data_o  = data_q;
      assign ready_o = ready_q;
    end else begin : g_comb
      assign data_o  = data_d;
      assign ready_o = ready_d;
    end
  endgenerate

endmodule

// File: rtl/register_file_multiport.sv
// Multi-port register file with prioritised write forwarding, optional zero
// register and a per-register busy scoreboard.
module register_file_multiport
  import regfile_pkg::*;
#(
  parameter int REG_WIDTH       = 8,
  parameter int ADDR_WIDTH      = 3,
  parameter int NUM_READ_PORTS  = 2,
  parameter int NUM_WRITE_PORTS = 1,
  parameter int READ_LATENCY    = 0,
  parameter int ZERO_REG        = 0
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic [NUM_WRITE_PORTS-1:0]            write,
  input  logic [NUM_WRITE_PORTS*ADDR_WIDTH-1:0] writeAddr,
  input  logic [NUM_WRITE_PORTS*REG_WIDTH-1:0]  writeData,
  input  logic                                  reserve,
  input  logic [ADDR_WIDTH-1:0]                 reserveAddr,
  input  logic [NUM_READ_PORTS*ADDR_WIDTH-1:0]  readAddr,
  output logic [NUM_READ_PORTS*REG_WIDTH-1:0]   readData,
  output logic [NUM_READ_PORTS-1:0]             readReady,
  output logic [num_regs(ADDR_WIDTH)-1:0]       busyVector
);

  localparam int NUM_REGS = num_regs(ADDR_WIDTH);

  // Writes are suppressed while reset is high, for storage and forwarding alike.
  logic [NUM_WRITE_PORTS-1:0]   wr_en;
  logic [MAX_WP-1:0]            wr_en_x;
  logic [ADDR_BUS_W-1:0]        waddr_x;
  logic [NUM_REGS*REG_WIDTH-1:0] regs_flat;
  logic [NUM_REGS-1:0]          busy_flat;

  assign wr_en   = write & ~{NUM_WRITE_PORTS{reset}};
  assign wr_en_x = MAX_WP'(wr_en);
  assign waddr_x = unpack_addrs(ADDR_BUS_W'(writeAddr), ADDR_WIDTH, NUM_WRITE_PORTS);

  generate
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_entry
      localparam bit IS_ZERO = (ZERO_REG != 0) && (i == 0);

      logic [REG_WIDTH-1:0] reg_q, reg_d;
      logic                 busy_q, busy_d;
      wr_hit_t              hit;

      always_comb begin
        hit    = resolve_write(wr_en_x, waddr_x, MAX_AW'(i));
        reg_d  = reg_q;
        busy_d = busy_q;
        if (hit.hit && !IS_ZERO) begin
          reg_d  = writeData[hit.port*REG_WIDTH +: REG_WIDTH];
          busy_d = 1'b0;
        end
        // A new reservation outranks a completing write to the same register.
        if (reserve && (reserveAddr == ADDR_WIDTH'(i)) && !IS_ZERO) begin
          busy_d = 1'b1;
        end
      end

      always_ff @(posedge clock) begin
        if (reset) begin
          reg_q  <= '0;
          busy_q <= 1'b0;
        end else begin
          reg_q  <= reg_d;
          busy_q <= busy_d;
        end
      end

      assign regs_flat[i*REG_WIDTH +: REG_WIDTH] = reg_q;
      assign busy_flat[i]                        = busy_q;
    end

    for (genvar r = 0; r < NUM_READ_PORTS; r++) begin : g_read
      regfile_read_port #(
        .REG_WIDTH      (REG_WIDTH),
        .ADDR_WIDTH     (ADDR_WIDTH),
        .NUM_WRITE_PORTS(NUM_WRITE_PORTS),
        .READ_LATENCY   (READ_LATENCY),
        .ZERO_REG       (ZERO_REG),
        .NUM_REGS       (NUM_REGS)
      ) u_read_port (
        .clock  (clock),
        .reset  (reset),
        .addr_i (readAddr[r*ADDR_WIDTH +: ADDR_WIDTH]),
        .regs_i (regs_flat),
        .busy_i (busy_flat),
        .wr_en_i(wr_en_x),
        .waddr_i(waddr_x),
        .wdata_i(writeData),
        .data_o (readData[r*REG_WIDTH +: REG_WIDTH]),
        .ready_o(readReady[r])
      );
    end
  endgenerate

  assign busyVector = busy_flat;

endmodule
